// File: rtl/core_frame_loader.sv
// Per-core frame receiver: snoops the scheduler bus, double-buffers addressed frames, streams instructions out.
// Define LOADER_ERR_EN to enable the sticky err flag for overflow and short-frame events.
module core_frame_loader #(
    parameter int unsigned INSTR_SIZE  = 16,
    parameter int unsigned FRAME_WORDS = 16,
    parameter int unsigned CORE_NUM    = 16,
    parameter int unsigned CORE_ID     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INSTR_SIZE-1:0] bus_data,
    input  logic                  bus_valid,
    input  logic                  bus_sof,
    input  logic [CORE_NUM-1:0]   bus_mask,
    input  logic                  bus_last,
    output logic                  core_reading,
    output logic                  core_ready,
    output logic                  slot_free,
    output logic [INSTR_SIZE-1:0] instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic                  task_done,
    output logic                  err
);

    localparam int unsigned       CNT_W    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(FRAME_WORDS - 1);
    localparam logic [CORE_NUM-1:0] MY_BIT = CORE_NUM'(1) << CORE_ID;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_SKIP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_wslot;
    logic                  r_rslot;
    logic [1:0]            r_fcnt;
    logic [CNT_W-1:0]      r_wcnt;
    logic [CNT_W-1:0]      r_rptr;
    logic [1:0]            r_last;
    logic                  r_busy;
    logic                  r_task_done;
    logic [INSTR_SIZE-1:0] r_mem [2][FRAME_WORDS];

    logic                  w_sof;
    logic                  w_hit;
    logic                  w_full;
    logic                  w_accept;
    logic                  w_word_done;
    logic                  w_commit;
    logic                  w_hs;
    logic                  w_release;
    logic                  w_wr_en;
    logic [CNT_W-1:0]      w_wr_idx;

    assign w_sof       = bus_valid & bus_sof;
    assign w_hit       = |(bus_mask & MY_BIT);
    assign w_full      = (r_fcnt == 2'd2);
    assign w_accept    = w_sof & w_hit & ~w_full;
    // Final word of a frame in progress; a sof always restarts the count instead.
    assign w_word_done = bus_valid & ~bus_sof & (r_state != S_IDLE) & (r_wcnt == LAST_IDX);
    assign w_commit    = w_word_done & (r_state == S_RECV);
    assign w_hs        = instr_valid & instr_ready;
    assign w_release   = w_hs & (r_rptr == LAST_IDX);
    assign w_wr_en     = w_accept | ((r_state == S_RECV) & bus_valid & ~bus_sof);
    assign w_wr_idx    = w_accept ? '0 : r_wcnt;

    // Receive FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Receive FSM next state: any sof (re)starts a frame, short frames are simply abandoned
    always_comb begin
        w_state_nxt = r_state;
        if (w_sof) begin
            w_state_nxt = w_accept ? S_RECV : S_SKIP;
        end else if (w_word_done) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Slot bookkeeping, drain pointer and task tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wslot     <= 1'b0;
            r_rslot     <= 1'b0;
            r_fcnt      <= 2'd0;
            r_wcnt      <= '0;
            r_rptr      <= '0;
            r_last      <= 2'b00;
            r_busy      <= 1'b0;
            r_task_done <= 1'b0;
        end else begin
            if (w_sof) begin
                r_wcnt <= CNT_W'(1);
            end else if (bus_valid && (r_state != S_IDLE)) begin
                r_wcnt <= w_word_done ? '0 : r_wcnt + 1'b1;
            end
            if (w_accept) r_last[r_wslot] <= bus_last;
            if (w_commit) r_wslot <= ~r_wslot;
            if (w_release) r_rslot <= ~r_rslot;
            case ({w_commit, w_release})
                2'b10:   r_fcnt <= r_fcnt + 2'd1;
                2'b01:   r_fcnt <= r_fcnt - 2'd1;
                default: r_fcnt <= r_fcnt;
            endcase
            if (w_release)  r_rptr <= '0;
            else if (w_hs)  r_rptr <= r_rptr + 1'b1;
            r_task_done <= w_release & r_last[r_rslot];
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (w_release && r_last[r_rslot]) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Instruction store, no reset needed: contents are only visible behind fcnt
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wslot][w_wr_idx] <= bus_data;
    end

`ifdef LOADER_ERR_EN
    logic r_err;
    logic w_overflow;
    logic w_short;

    assign w_overflow = w_sof & w_hit & w_full;
    assign w_short    = w_sof & (r_state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      r_err <= 1'b0;
        else if (w_overflow || w_short)  r_err <= 1'b1;
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign instr_valid  = (r_fcnt != 2'd0);
    assign slot_free    = (r_fcnt != 2'd2);
    assign core_ready   = ~r_busy;
    assign task_done    = r_task_done;
    assign core_reading = (r_state == S_RECV) | w_accept;
    assign instr        = instr_valid ? r_mem[r_rslot][r_rptr] : '0;

endmodule

// File: doc/core_frame_loader.md
# core_frame_loader

Per-core frame receiver sitting directly downstream of the task scheduler (`new_sched`). It snoops the shared 16-bit scheduler-to-core bus and captures frames addressed to its core into a double-buffered instruction store. It hands instructions to the core pipeline over a valid/ready handshake and reports `core_ready` back to the scheduler. One instance exists per core; `CORE_NUM` instances form the 16-bit `core_ready` vector.

## Interface

Parameters:
- `INSTR_SIZE`, 16: instruction/bus word width.
- `FRAME_WORDS`, 16: words per frame (FRAME_SIZE/INSTR_SIZE).
- `CORE_NUM`, 16: width of the destination mask.
- `CORE_ID`, 0: this core's bit in the mask.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low (0 = reset).
- `bus_data`, in, INSTR_SIZE: bus word.
- `bus_valid`, in, 1: `bus_data` valid this cycle (scheduler `frame_being_sent`).
- `bus_sof`, in, 1: qualifies word 0 of a frame; valid only with `bus_valid`.
- `bus_mask`, in, CORE_NUM: destination cores; sampled on the sof word.
- `bus_last`, in, 1: frame is the task's last; sampled on the sof word.
- `core_reading`, out, 1: frame for this core is being captured.
- `core_ready`, out, 1: no task in flight; core can accept a new task.
- `slot_free`, out, 1: at least one frame buffer is empty.
- `instr`, out, INSTR_SIZE: current instruction.
- `instr_valid`, out, 1: `instr` valid.
- `instr_ready`, in, 1: core consumes `instr` when high with `instr_valid`.
- `task_done`, out, 1: one-cycle pulse after the last instruction of a task is consumed.
- `err`, out, 1: sticky protocol error (see Configuration).

## Operation

- Storage: 2 frame slots × FRAME_WORDS words. Write slot pointer `wslot`, read slot pointer `rslot`, full count `fcnt` ∈ {0,1,2}. Each slot carries a `last` flag.
- Receive FSM:
  - IDLE: on `bus_valid & bus_sof & bus_mask[CORE_ID]`, write word 0 to `wslot`, latch `last`, set word count to 1 and go to RECV.
  - Sof not addressed to this core: go to SKIP.
  - If `fcnt==2` (overflow): go to SKIP and flag the error.
  - RECV: each `bus_valid` word is written at the word count, then the count increments. On word FRAME_WORDS-1: commit (`fcnt`+1, `wslot` toggles) and return to IDLE. Gaps with `bus_valid` low are allowed.
  - SKIP: count words without writing; return to IDLE after FRAME_WORDS words.
- Sof arriving in RECV/SKIP before the count completes (short frame): discard the partial slot (no commit), flag the error, and treat the sof as a new frame (same rules as IDLE).
- Drain: `instr_valid = (fcnt!=0)`; `instr = slot[rslot][rptr]`. On handshake `rptr`+1. At `rptr==FRAME_WORDS-1`: release the slot (`fcnt`-1, `rslot` toggles, `rptr`=0). If the slot's `last` flag is set, pulse `task_done` the next cycle.
- Commit and release in the same cycle: `fcnt` unchanged, both pointers toggle.
- Task tracking: `busy` sets on an accepted addressed sof and clears with `task_done`. `core_ready = ~busy`; `slot_free = (fcnt!=2)`.
- `core_reading` is high in RECV and on the accepted sof cycle (combinational from sof match).

## Timing

- Reset values: `core_ready`=1, `slot_free`=1, `core_reading`=0, `instr_valid`=0, `task_done`=0, `err`=0, `instr`=0. Pointers, counts and FSM are zero/IDLE.
- `core_ready` falls the cycle after the accepted sof edge.
- `instr_valid` rises the cycle after the edge capturing the frame's final word (latency 1).
- `task_done` is high for exactly the cycle after the last handshake; `core_ready` rises in that same cycle.
- Reset asserted mid-frame or mid-drain: all content is discarded and outputs return to reset values asynchronously.
- Back-to-back frames (sof immediately after a commit) are accepted without a bubble.

## Configuration

- `LOADER_ERR_EN` defined: overflow and short-frame events set `err`. `err` is sticky until reset.
- `LOADER_ERR_EN` undefined: `err` is tied 0. Overflow frames are still skipped silently and short frames still discarded; the datapath is otherwise identical.

## Test plan

- Single-frame task, mask 0x000f, CORE_ID=0, words 0x0100..0x010F with `bus_last`=1, `instr_ready`=1: `instr_valid` rises 1 cycle after word 15; 0x0100..0x010F are issued in order; `task_done` pulses once; `core_ready` goes 0→1.
- Mask 0x00f0 with CORE_ID=0: no write and `core_reading` stays 0; `core_ready` stays 1; `instr_valid` stays 0.
- Three frames with `instr_ready`=0: frames 1–2 commit and `slot_free`=0; frame 3 is skipped with `err`=1 (macro on) or 0 (macro off). Releasing `instr_ready` yields exactly 32 instructions.
- Sof after 5 words of a frame: the partial frame is discarded, `err`=1, and the new frame is captured intact.
- `instr_ready` toggling every cycle while the second frame streams in: the commit/release coincidence keeps `fcnt` correct, with no lost or duplicated word.
- Reset pulled low mid-RECV: outputs return to reset values immediately; a subsequent frame loads correctly.
